// File: rtl/tone_pkg.sv
// Shared constants for the tone period detector: note codes, nominal full
// periods at 100 MHz and FSM state encodings.
package tone_pkg;

    localparam int NUM_NOTES = 8;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    // B4 is 2 x 101_241 so it matches the existing 494 Hz generator exactly.
    localparam int unsigned NOTE_NOM [NUM_NOTES] = '{
        382_219, 340_530, 303_370, 286_344,
        255_102, 227_273, 202_482, 191_113
    };

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [3:0] note_code(input int idx);
        return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/note_classifier.sv
// Combinational match of a measured full period against the nominal note
// table; the first entry within tolerance wins, otherwise NOTE_NONE.
module note_classifier
    import tone_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 1_000,
    parameter int TOL_SHIFT  = 6
) (
    input  logic [CNT_W-1:0] period_i,
    output logic [3:0]       note_o
);

    logic [NUM_NOTES-1:0] match;
    logic [CNT_W:0]       period_w;

    // One extra bit so the absolute difference never wraps.
    assign period_w = {1'b0, period_i};

    generate
        for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_note
            localparam logic [CNT_W:0] NOM = (CNT_W+1)'(NOTE_NOM[gi]);
            localparam logic [CNT_W:0] TOL = NOM >> TOL_SHIFT;
            logic [CNT_W:0] diff;

            assign diff       = (period_w >= NOM) ? (period_w - NOM) : (NOM - period_w);
            assign match[gi]  = (diff <= TOL);
        end
    endgenerate

    always_comb begin
        note_o = NOTE_NONE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (match[i]) begin
                note_o = note_code(i);
            end
        end
        if (period_i < CNT_W'(MIN_PERIOD)) begin
            note_o = NOTE_NONE;
        end
    end

endmodule

// File: rtl/tone_period_detector.sv
// Measures the full period of an asynchronous square wave in clk cycles,
// classifies it to a note code and tracks tone presence with a silence timeout.
module tone_period_detector
    import tone_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MIN_PERIOD  = 1_000,
    parameter int TOL_SHIFT   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [3:0]       note,
    output logic             tone_present
);

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [3:0]       note_q, note_d;
    logic             valid_q, valid_d;
    logic             present_q;
    logic [3:0]       class_note;

    // Synchronizer only honours rst_n so it keeps tracking the pin while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tone_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    note_classifier #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD),
        .TOL_SHIFT  (TOL_SHIFT)
    ) u_classifier (
        .period_i (cnt_q),
        .note_o   (class_note)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        note_d   = note_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_ARMED;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_ARMED, ST_LOCKED: begin
                // A rise on the timeout cycle still counts as a measurement.
                if (rise) begin
                    state_d  = ST_LOCKED;
                    cnt_d    = CNT_W'(1);
                    period_d = cnt_q;
                    note_d   = class_note;
                    valid_d  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    period_d = '0;
                    note_d   = NOTE_NONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                period_d = '0;
                note_d   = NOTE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            note_q    <= NOTE_NONE;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            present_q <= (state_d == ST_LOCKED);
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign note         = note_q;
    assign tone_present = present_q;

endmodule

// File: tb/tb_tone_period_detector.sv
// Directed bench for tone_period_detector: note matching, tolerance edges,
// silence timeout, timeout/rise coincidence and en / rst_n restarts.
`timescale 1ns/1ps
module tb_tone_period_detector;

    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 1_000_000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             tone_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [3:0]       note;
    logic             tone_present;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_period_detector #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT),
        .MIN_PERIOD  (1_000),
        .TOL_SHIFT   (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tone_in      (tone_in),
        .period       (period),
        .period_valid (period_valid),
        .note         (note),
        .tone_present (tone_present)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid, input int exp_period,
                                 input int exp_note, input logic exp_present);
        check({tag, " valid"},   32'(period_valid), 32'(exp_valid));
        check({tag, " period"},  32'(period),       32'(exp_period));
        check({tag, " note"},    32'(note),         32'(exp_note));
        check({tag, " present"}, 32'(tone_present), 32'(exp_present));
    endtask

    // One rise-to-rise interval of hi+lo cycles; the expectations describe the
    // outputs right after this rise, i.e. the interval that just ended.
    task automatic tone_cycle(input int hi, input int lo, input logic exp_valid,
                              input int exp_period, input int exp_note,
                              input logic exp_present, input string tag);
        @(negedge clk) tone_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs(tag, exp_valid, exp_period, exp_note, exp_present);
        @(posedge clk);
        #1;
        check({tag, " pulse_end"}, 32'(period_valid), 32'd0);
        repeat (hi - 4) @(posedge clk);
        @(negedge clk) tone_in = 1'b0;
        repeat (lo) @(posedge clk);
        $display("step %s done: period=%0d note=%0d present=%0d", tag, period, note, tone_present);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        tone_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 0, 0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // B4 loopback tone.
        tone_cycle(101_241, 101_241, 1'b0, 0,       0, 1'b0, "b4_first");
        tone_cycle(101_241, 101_241, 1'b1, 202_482, 7, 1'b1, "b4_1");
        tone_cycle(101_241, 101_241, 1'b1, 202_482, 7, 1'b1, "b4_2");
        // A4, then a mid-stream step to C4.
        tone_cycle(113_636, 113_636, 1'b1, 202_482, 7, 1'b1, "b4_3");
        tone_cycle(113_636, 113_636, 1'b1, 227_272, 6, 1'b1, "a4_1");
        tone_cycle(191_110, 191_110, 1'b1, 227_272, 6, 1'b1, "a4_2");
        // Out-of-tolerance and below-minimum periods.
        tone_cycle(107_500, 107_500, 1'b1, 382_220, 1, 1'b1, "c4");
        tone_cycle(250,     250,     1'b1, 215_000, 0, 1'b1, "between_a4_b4");
        tone_cycle(250,     250,     1'b1, 500,     0, 1'b1, "glitch");

        // Silence: last rise was 500 cycles before the return of the previous step.
        repeat (TIMEOUT - 500 + 2) @(posedge clk);
        #1;
        check("timeout_minus1 present", 32'(tone_present), 32'd1);
        @(posedge clk);
        #1;
        check_outputs("timeout", 1'b0, 0, 0, 1'b0);

        tone_cycle(101_241, 101_241, 1'b0, 0,       0, 1'b0, "after_timeout_armed");
        tone_cycle(500_000, 500_000, 1'b1, 202_482, 7, 1'b1, "relock");
        // Rise exactly when cnt reaches the timeout value.
        tone_cycle(101_241, 101_241, 1'b1, TIMEOUT, 0, 1'b1, "rise_at_timeout");
        tone_cycle(101_241, 101_241, 1'b1, 202_482, 7, 1'b1, "post_coincide");

        // en dropped mid-period while LOCKED.
        @(negedge clk) en = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("en_low", 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) en = 1'b1;
        tone_cycle(101_241, 101_241, 1'b0, 0,       0, 1'b0, "en_first");
        tone_cycle(101_241, 101_241, 1'b1, 202_482, 7, 1'b1, "en_second");

        // Same again with a one-cycle rst_n pulse.
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_pulse", 1'b0, 0, 0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tone_cycle(101_241, 101_241, 1'b0, 0,       0, 1'b0, "rst_first");
        tone_cycle(101_241, 101_241, 1'b1, 202_482, 7, 1'b1, "rst_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
